// File: rtl/serial_pattern_tx_if.sv
// Request/status bundle for serial_pattern_tx. The bus master posts start/data/reps.
// The transmitter (slave) returns the serial bit w, busy/done status and its FSM state for debug.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int REPW  = 4
);
  // Handshake: the master holds start high for one or more cycles. The slave
  // accepts start only in IDLE with reps != 0 (there is no ready signal).
  // busy high, or done high, means a start in that cycle is dropped.
  logic             start;
  logic [WIDTH-1:0] data;
  logic [REPW-1:0]  reps;
  logic             w;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (output start, data, reps, input w, busy, done, state_dbg);
  modport slave  (input start, data, reps, output w, busy, done, state_dbg);
endinterface

// File: rtl/serial_pattern_tx.sv
// Serializer that sends a captured pattern MSB first, reps times, with GAP idle-low cycles between frames.
// All outputs are registered and change only with state, never directly with the inputs.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int REPW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_pattern_tx_if.slave bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [WIDTH-1:0]  pat_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [REPW-1:0]   rep_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic              w_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      w_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && (bus.reps != '0)) begin
            shreg_q   <= bus.data;
            pat_q     <= bus.data;
            rep_cnt_q <= bus.reps;
            bit_cnt_q <= '0;
            w_q       <= bus.data[WIDTH-1];
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            if (rep_cnt_q > REPW'(1)) begin
              rep_cnt_q <= rep_cnt_q - REPW'(1);
              shreg_q   <= pat_q;
              if (GAP > 0) begin
                gap_cnt_q <= '0;
                w_q       <= 1'b0;
                state_q   <= S_GAP;
              end else begin
                // Zero gap: the next frame's MSB follows the last bit directly.
                w_q     <= pat_q[WIDTH-1];
                state_q <= S_SEND;
              end
            end else begin
              w_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            w_q       <= shreg_q[WIDTH-2];
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            w_q     <= shreg_q[WIDTH-1];
            state_q <= S_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.w         = w_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one instance with GAP=2 and one with GAP=0, fed by hand-computed stream vectors.
// Observed streams are packed with cycle 1 in the most significant bit.
module tb_serial_pattern_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(8), .REPW(4)) ifa ();
  serial_pattern_tx_if #(.WIDTH(8), .REPW(4)) ifb ();

  serial_pattern_tx #(.WIDTH(8), .GAP(2), .REPW(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  serial_pattern_tx #(.WIDTH(8), .GAP(0), .REPW(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] d, input logic [3:0] r);
    if (sel == 0) begin
      ifa.start = s; ifa.data = d; ifa.reps = r;
    end else begin
      ifb.start = s; ifb.data = d; ifb.reps = r;
    end
  endtask

  task automatic sample(input int sel, output logic w, output logic b, output logic dn);
    if (sel == 0) begin
      w = ifa.w; b = ifa.busy; dn = ifa.done;
    end else begin
      w = ifb.w; b = ifb.busy; dn = ifb.done;
    end
  endtask

  // Start at edge 0, then record cycles 1..n. Outside the injected cycle, data and
  // reps are scrambled to show the captured frame is immune to later input changes.
  task automatic run(input int sel, input logic [7:0] d, input logic [3:0] r, input int n,
                     input int inj, output logic [63:0] ow, output logic [63:0] ob,
                     output logic [63:0] od);
    logic w, b, dn;
    ow = '0; ob = '0; od = '0;
    @(negedge clk);
    drive(sel, 1'b1, d, r);
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == inj) drive(sel, 1'b1, 8'h00, 4'd1);
      else          drive(sel, 1'b0, ~d, 4'd0);
      sample(sel, w, b, dn);
      ow = {ow[62:0], w};
      ob = {ob[62:0], b};
      od = {od[62:0], dn};
    end
  endtask

  logic [63:0] ow, ob, od, zv;
  logic        sw, sb, sd, prev;

  initial begin
    drive(0, 1'b0, 8'h00, 4'd0);
    drive(1, 1'b0, 8'h00, 4'd0);
    #12;
    check("rst_a_out", {61'd0, ifa.w, ifa.busy, ifa.done}, 64'd0);
    check("rst_a_state", {62'd0, ifa.state_dbg}, 64'd0);
    check("rst_b_out", {61'd0, ifb.w, ifb.busy, ifb.done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 1011_0010.
    run(0, 8'b1011_0010, 4'd1, 10, -1, ow, ob, od);
    check("single_w", ow, 64'(10'b1011001000));
    check("single_busy", ob, 64'(10'b1111111100));
    check("single_done", od, 64'(10'b0000000010));

    // Two frames of A5 separated by a 2-cycle gap.
    run(0, 8'hA5, 4'd2, 20, -1, ow, ob, od);
    check("rep_w", ow, 64'(20'b10100101001010010100));
    check("rep_busy", ob, 64'(20'b11111111111111111100));
    check("rep_done", od, 64'(20'b00000000000000000010));

    // Zero gap: three back-to-back F0 frames.
    run(1, 8'hF0, 4'd3, 26, -1, ow, ob, od);
    check("b2b_w", ow, 64'({24'hF0F0F0, 2'b00}));
    check("b2b_busy", ob, 64'({24'hFFFFFF, 2'b00}));
    check("b2b_done", od, 64'(26'b10));

    // reps=0 is not a request.
    run(0, 8'hAA, 4'd0, 4, -1, ow, ob, od);
    check("reps0_w", ow, 64'd0);
    check("reps0_busy", ob, 64'd0);
    check("reps0_done", od, 64'd0);
    check("reps0_state", {62'd0, ifa.state_dbg}, 64'd0);

    // start with data=00 during cycle 4 of an FF frame must be dropped.
    run(0, 8'hFF, 4'd1, 12, 4, ow, ob, od);
    check("busy_start_w", ow, 64'(12'hFF0));
    check("busy_start_busy", ob, 64'(12'hFF0));
    check("busy_start_done", od, 64'(12'b000000001000));

    // Asynchronous reset in the middle of cycle 5 of a frame.
    @(negedge clk);
    drive(0, 1'b1, 8'hFF, 4'd3);
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 8'hFF, 4'd3);
    end
    sample(0, sw, sb, sd);
    check("pre_rst", {61'd0, sw, sb, sd}, 64'b110);
    #1 rst = 1'b0;
    #1;
    sample(0, sw, sb, sd);
    check("async_rst_out", {61'd0, sw, sb, sd}, 64'd0);
    check("async_rst_state", {62'd0, ifa.state_dbg}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ow = '0; od = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sample(0, sw, sb, sd);
      ow = {ow[62:0], sw | sb};
      od = {od[62:0], sd};
    end
    check("post_rst_idle", ow, 64'd0);
    check("post_rst_no_done", od, 64'd0);
    run(0, 8'h81, 4'd1, 10, -1, ow, ob, od);
    check("after_rst_w", ow, 64'(10'b1000000100));
    check("after_rst_busy", ob, 64'(10'b1111111100));
    check("after_rst_done", od, 64'(10'b0000000010));

    // Loopback into a "11" overlapping detector (z = w & previous w).
    run(0, 8'b0110_1100, 4'd2, 20, -1, ow, ob, od);
    check("loop_w", ow, 64'(20'b01101100000110110000));
    zv = '0;
    prev = 1'b0;
    for (int i = 19; i >= 0; i--) begin
      zv = {zv[62:0], prev & ow[i]};
      prev = ow[i];
    end
    check("loop_z", zv, 64'(20'b00100100000010010000));
    check("loop_done", od, 64'(20'b00000000000000000010));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
